// File: rtl/nios2_c_pio_pkg.sv
// nios2_c_pio_pkg: register offsets shared by the input and output PIO blocks
package nios2_c_pio_pkg;

    typedef enum logic [1:0] {
        PIO_DATA    = 2'd0,
        PIO_RSVD    = 2'd1,
        PIO_IRQMASK = 2'd2,
        PIO_EDGECAP = 2'd3
    } pio_reg_e;

endpackage

// File: rtl/nios2_c_keyin_debounce.sv
// nios2_c_keyin_debounce: per-bit debouncer, accepts a level only after it persists DEBOUNCE_CYCLES cycles
module nios2_c_keyin_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sync,
    output logic o_cond
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_cond;

    // count consecutive cycles of disagreement; any return to the held level restarts the count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_cond <= 1'b1;
        end else if (i_sync == r_cond) begin
            r_cnt  <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt  <= '0;
            r_cond <= i_sync;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_cond = r_cond;

endmodule

// File: rtl/nios2_c_keyin.sv
// nios2_c_keyin: Avalon-MM key input PIO with edge capture and irq; debounce via NIOS2_C_KEYIN_DEBOUNCE_EN
module nios2_c_keyin
    import nios2_c_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [31:0]      r_readdata;
    logic             r_irq;
    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd;
    logic             w_wr;
    logic             w_unused;

    // two-flop synchronizer; released (all ones) out of reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef NIOS2_C_KEYIN_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        nios2_c_keyin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .i_sync (r_sync2[i]),
            .o_cond (w_cond[i])
        );
    end
    assign w_unused = &{1'b0, writedata};
`else
    assign w_cond   = r_sync2;
    assign w_unused = &{1'b0, writedata, DEBOUNCE_CYCLES[0]};
`endif

    assign w_wr   = chipselect && !write_n;
    assign w_fall = r_prev & ~w_cond;
    assign w_clr  = (w_wr && address == PIO_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // read mux; upper bits are zero because every source is zero-extended
    always_comb begin
        w_rd = (address == PIO_DATA)    ? 32'(w_cond) :
               (address == PIO_IRQMASK) ? 32'(r_mask) :
               (address == PIO_EDGECAP) ? 32'(r_edge) : 32'd0;
    end

    // edge capture (a new press beats a same-cycle clear), mask, registered read data and irq
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev     <= '1;
            r_mask     <= '0;
            r_edge     <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= w_cond;
            r_mask     <= (w_wr && address == PIO_IRQMASK) ? writedata[WIDTH-1:0] : r_mask;
            r_edge     <= (r_edge & ~w_clr) | w_fall;
            r_readdata <= w_rd;
            r_irq      <= |(r_edge & r_mask);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
